// File: rtl/cipher_out_buffer_if.sv
// Ciphertext stream bundle: producer side (IN/in_valid) and consumer side (OUT/out_valid/out_ready).
// The buffer takes the slave view; the producer/consumer environment takes the master view.
interface cipher_out_buffer_if #(
   parameter int BLOCK_LENGTH = 128
);
   logic [BLOCK_LENGTH-1:0] IN;
   logic                    in_valid;
   logic [BLOCK_LENGTH-1:0] OUT;
   logic                    out_valid;
   logic                    out_ready;

   modport slave (
      input  IN,
      input  in_valid,
      input  out_ready,
      output OUT,
      output out_valid
   );

   modport master (
      output IN,
      output in_valid,
      output out_ready,
      input  OUT,
      input  out_valid
   );
endinterface

// File: rtl/cipher_out_buffer.sv
// Output FWFT FIFO behind the final AES round: queues ciphertexts, counts deliveries and drops.
// Latency: a push into an empty FIFO appears on OUT the next cycle (no bypass).
// Backpressure: none toward the pipeline; input arriving while full without a pop is dropped.
module cipher_out_buffer #(
   parameter int BLOCK_LENGTH = 128,
   parameter int DEPTH        = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   cipher_out_buffer_if.slave       bus,
   input  logic                     clear_overflow,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_WIDTH-1:0]     delivered_count,
   output logic [CNT_WIDTH-1:0]     dropped_count
);
   localparam int             AW   = $clog2(DEPTH);
   localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

   logic [BLOCK_LENGTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [AW:0]             r_level;
   logic [BLOCK_LENGTH-1:0] r_out;
   logic                    r_out_valid;
   logic                    r_overflow;
   logic [CNT_WIDTH-1:0]    r_delivered;
   logic [CNT_WIDTH-1:0]    r_dropped;

   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;
   logic [AW-1:0]           w_rd_ptr_nxt;
   logic [AW:0]             w_level_nxt;
   logic [BLOCK_LENGTH-1:0] w_head_nxt;

   always_comb begin
      w_pop        = r_out_valid & bus.out_ready;
      w_push       = bus.in_valid & ((r_level != FULL) | w_pop);
      w_drop       = bus.in_valid & (r_level == FULL) & ~w_pop;
      w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

      w_level_nxt = r_level;
      if (w_push && !w_pop)
         w_level_nxt = r_level + (AW+1)'(1);
      else if (w_pop && !w_push)
         w_level_nxt = r_level - (AW+1)'(1);

      // OUT is registered, so look ahead: the next head is the incoming block
      // when it lands in the slot the read pointer is about to point at.
      w_head_nxt = '0;
      if (w_level_nxt != '0) begin
         if (w_push && (r_wr_ptr == w_rd_ptr_nxt))
            w_head_nxt = bus.IN;
         else
            w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push)
         r_mem[r_wr_ptr] <= bus.IN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_delivered <= '0;
         r_dropped   <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_level     <= w_level_nxt;
         r_out       <= w_head_nxt;
         r_out_valid <= (w_level_nxt != '0);
         if (w_pop)
            r_delivered <= r_delivered + CNT_WIDTH'(1);
         if (w_drop && (r_dropped != '1))
            r_dropped <= r_dropped + CNT_WIDTH'(1);
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_overflow)
            r_overflow <= 1'b0;
      end
   end

   assign bus.OUT         = r_out;
   assign bus.out_valid   = r_out_valid;
   assign level           = r_level;
   assign overflow        = r_overflow;
   assign delivered_count = r_delivered;
   assign dropped_count   = r_dropped;
endmodule

// File: tb/tb_cipher_out_buffer.sv
// Bench for cipher_out_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_cipher_out_buffer;
   localparam int BL = 128;
   localparam int D  = 4;
   localparam int CW = 16;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear_overflow;
   logic [2:0]    level;
   logic          overflow;
   logic [CW-1:0] delivered_count;
   logic [CW-1:0] dropped_count;

   always #5 clk = ~clk;

   cipher_out_buffer_if #(.BLOCK_LENGTH(BL)) bus ();

   cipher_out_buffer #(
      .BLOCK_LENGTH (BL),
      .DEPTH        (D),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .clear_overflow  (clear_overflow),
      .level           (level),
      .overflow        (overflow),
      .delivered_count (delivered_count),
      .dropped_count   (dropped_count)
   );

   // reference model state
   logic [BL-1:0] m_q [$];
   int            m_deliv;
   int            m_drop;
   logic          m_ovf;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic iv, input logic [BL-1:0] d,
                       input logic rdy, input logic clr);
      bit pop;
      bit full;
      bit drop;
      rst            = r;
      bus.in_valid   = iv;
      bus.IN         = d;
      bus.out_ready  = rdy;
      clear_overflow = clr;
      if (r) begin
         m_q.delete();
         m_deliv = 0;
         m_drop  = 0;
         m_ovf   = 1'b0;
      end else begin
         pop  = rdy && (m_q.size() != 0);
         full = (m_q.size() == D);
         drop = iv && full && !pop;
         if (pop) begin
            void'(m_q.pop_front());
            m_deliv = (m_deliv + 1) % (CNT_MAX + 1);
         end
         if (iv && !drop)
            m_q.push_back(d);
         if (drop) begin
            if (m_drop < CNT_MAX) m_drop++;
            m_ovf = 1'b1;
         end else if (clr) begin
            m_ovf = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", BL'(bus.out_valid), BL'(m_q.size() != 0));
      check("OUT", bus.OUT, (m_q.size() != 0) ? m_q[0] : '0);
      check("level", BL'(level), BL'(m_q.size()));
      check("overflow", BL'(overflow), BL'(m_ovf));
      check("delivered_count", BL'(delivered_count), BL'(m_deliv));
      check("dropped_count", BL'(dropped_count), BL'(m_drop));
   endtask

   function automatic logic [BL-1:0] rnd_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [BL-1:0] a;
      logic [BL-1:0] ones;
      a    = 128'h3925841d02dc09fbdc118597196a0b32;
      ones = '1;
      rst = 1'b1; bus.in_valid = 1'b0; bus.IN = '0; bus.out_ready = 1'b0; clear_overflow = 1'b0;

      // reset, with in_valid asserted during reset to show it is ignored
      step(1'b1, 1'b1, rnd_blk(), 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);

      // single block, consumer ready
      step(1'b0, 1'b1, a, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);

      // fill with consumer stalled, then drain in order
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_blk(), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

      // overflow: fill, drop B4, drain, then clear the flag
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_blk(), 1'b0, 1'b0);
      step(1'b0, 1'b1, rnd_blk(), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // full with simultaneous push and pop across the pointer wrap
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_blk(), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_blk(), 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

      // idle bus carrying garbage data
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, ones, 1'b1, 1'b0);

      // mid-stream reset with level=3 and overflow set
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd_blk(), 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b1, rnd_blk(), 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);

      // random traffic with varying pressure, occasional clears and resets
      for (int i = 0; i < 800; i++) begin
         int p_in;
         int p_rdy;
         p_in  = (i < 400) ? 3 : 1;
         p_rdy = (i < 400) ? 1 : 3;
         step(($urandom_range(0, 249) == 0),
              ($urandom_range(0, 3) < p_in),
              rnd_blk(),
              ($urandom_range(0, 3) < p_rdy),
              ($urandom_range(0, 15) == 0));
      end

      // saturate dropped_count; a clear in the same cycle as a drop loses
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_blk(), 1'b0, 1'b0);
      for (int i = 0; i < CNT_MAX + 5; i++)
         step(1'b0, 1'b1, rnd_blk(), 1'b0, (i % 20000) == 7);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cipher_out_buffer.md
Name: cipher_out_buffer

Overview:
- Output stage directly downstream of the final encryption round register in the pipelined AES-128 datapath.
- Captures each 128-bit ciphertext the final round produces, tagged by a valid bit that travels alongside the pipeline.
- Queues ciphertexts in a small first-word-fall-through FIFO and presents them to the consumer over a valid/ready handshake.
- The round pipeline cannot stall, so the block detects overflow, counts dropped blocks and counts delivered blocks.

Parameters:
- BLOCK_LENGTH, 128, ciphertext width in bits.
- DEPTH, 4, number of FIFO entries. Power of two, at least 2.
- CNT_WIDTH, 16, width of the delivered and dropped counters.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- IN  input  BLOCK_LENGTH  ciphertext from the final round register.
- in_valid  input  1  IN carries a real block this cycle. Zero blocks emitted while the round is disabled arrive with in_valid=0.
- OUT  output  BLOCK_LENGTH  head-of-FIFO ciphertext.
- out_valid  output  1  OUT holds a valid block.
- out_ready  input  1  consumer accepts OUT this cycle.
- clear_overflow  input  1  clears the overflow flag.
- level  output  log2(DEPTH)+1  number of occupied entries.
- overflow  output  1  sticky flag: a block was dropped.
- delivered_count  output  CNT_WIDTH  handshakes completed.
- dropped_count  output  CNT_WIDTH  blocks lost to a full FIFO.

Behaviour:
- Reset (rst=1 at a clk edge):
  - level=0, out_valid=0, OUT=0, overflow=0, both counters=0.
  - Read and write pointers go to 0.
  - Stored contents are discarded, including when reset arrives mid-stream.
  - in_valid is ignored during the reset cycle.
- Event definitions:
  - pop = out_valid & out_ready.
  - push = in_valid & (level<DEPTH | pop).
  - drop = in_valid & level==DEPTH & !pop.
- Level update: increments on push only, decrements on pop only, unchanged on push and pop together.
- Push with pop while full is legal. The head leaves, the new block is written, level stays at DEPTH, and nothing is dropped.
- Latency: a push into an empty FIFO gives out_valid=1 and OUT=that block on the next cycle. There is no same-cycle bypass.
- OUT is the head entry whenever out_valid=1. OUT is driven to 0 when empty.
- OUT and out_valid stay stable while out_valid=1 and out_ready=0.
- out_valid = (level!=0). It is registered and consistent with level.
- Pointers wrap modulo DEPTH. Data order is strictly FIFO.
- Drop handling:
  - A dropped block leaves the FIFO contents unchanged.
  - dropped_count increments by 1. It saturates at all-ones and does not wrap.
  - overflow is set to 1 on the following cycle.
- Overflow flag:
  - clear_overflow=1 clears overflow on the next cycle.
  - If a drop and clear_overflow occur in the same cycle, overflow is 1 (set wins).
  - clear_overflow does not reset dropped_count.
- delivered_count increments by 1 on every pop and wraps modulo 2^CNT_WIDTH.
- out_ready while empty has no effect.
- in_valid=0 with nonzero IN has no effect.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then push A=128'h3925841d02dc09fbdc118597196a0b32 with out_ready=1 → out_valid=1 and OUT=A one cycle later; delivered_count=1 after the handshake.
- out_ready=0, push 4 blocks B0..B3 → level=4, OUT=B0 held stable. Then out_ready=1 for 4 cycles → B0,B1,B2,B3 in order, level returns to 0, out_valid=0.
- FIFO full and out_ready=0, push B4 → B4 dropped, dropped_count=1, overflow=1. Drain yields B0..B3 only. Assert clear_overflow → overflow=0, dropped_count still 1.
- FIFO full, in_valid=1 and out_ready=1 together for 3 cycles → no drops, level stays 4, output order preserved across pointer wrap.
- in_valid=0 with IN=128'hFFFF…F for 10 cycles → level stays 0, counters unchanged.
- Reset with level=3 and overflow=1 → next cycle level=0, out_valid=0, OUT=0, overflow=0, counters=0. The next push is delivered normally.
